// File: rtl/cr_ahb2apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cr_ahb2apb_pkg
//  Description : Shared types and constants for the AHB-Lite to APB3 bridge.
//                - state_e   : bridge FSM state encoding
//                - HTRANS_*  : AHB transfer type codes
//                - HRESP_*   : AHB response codes
//                - size_ok() : true when an AHB HSIZE fits in the data bus
//  Revision    : 1.0 - initial release
// ============================================================================
package cr_ahb2apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // HSIZE encodes log2(bytes); anything wider than the data bus is rejected.
  function automatic logic size_ok(input logic [2:0] hsize, input int unsigned data_w);
    int unsigned max_size;
    max_size = $clog2(data_w / 8);
    return ({29'd0, hsize} <= max_size);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cr_apb_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : cr_apb_timeout_cnt
//  Description : Counts APB ACCESS cycles and flags the last permitted one.
//                Clear has priority over enable. With TIMEOUT = 0 the counter
//                is removed and o_expired is tied low.
//  Ports       : clk, rst   - clock, asynchronous active-high reset
//                i_clr      - reset count to zero
//                i_en       - count this cycle
//                o_expired  - i_en and count == TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
module cr_apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  generate
    if (TIMEOUT > 0) begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] r_count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= '0;
        end else if (i_clr) begin
          r_count <= '0;
        end else if (i_en) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign o_expired = i_en && (r_count == C_LAST);
    end else begin : g_off
      logic w_unused;
      assign w_unused  = &{1'b0, clk, rst, i_clr, i_en};
      assign o_expired = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cr_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : cr_ahb2apb_bridge
//  Description : AHB-Lite slave to APB3 master bridge. Each NONSEQ/SEQ
//                transfer becomes one APB SETUP+ACCESS transaction, with AHB
//                wait states until it completes. PSLVERR, oversize HSIZE and
//                APB timeout produce a two-cycle AHB ERROR response.
//  Ports       : clk, rst                       - clock, async active-high reset
//                hsel, haddr, htrans, hwrite,
//                hsize, hwdata, hready          - AHB-Lite slave inputs
//                hreadyout, hresp, hrdata       - AHB-Lite slave outputs
//                paddr, psel, penable, pwrite,
//                pwdata                         - APB3 master outputs
//                prdata, pready, pslverr        - APB3 master inputs
//  Revision    : 1.0 - initial release
// ============================================================================
module cr_ahb2apb_bridge
  import cr_ahb2apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  state_e            r_state;
  logic              r_hreadyout;
  logic              r_hresp;
  logic [DATA_W-1:0] r_hrdata;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;

  logic w_active_trans;
  logic w_accept;
  logic w_in_access;
  logic w_expired;

  assign w_active_trans = !((htrans == HTRANS_IDLE) || (htrans == HTRANS_BUSY)) &&
                          ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign w_accept       = hsel && hready && w_active_trans;
  assign w_in_access    = (r_state == ST_ACCESS);

  cr_apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (!w_in_access),
    .i_en      (w_in_access),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= '0;
      r_paddr     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
    end else begin
      case (r_state)
        // Idle-like states: the AHB data phase (if any) finishes this cycle,
        // so a new address phase may be accepted here.
        ST_IDLE, ST_DONE, ST_ERR2: begin
          if (w_accept) begin
            r_hreadyout <= 1'b0;
            if (!size_ok(hsize, DATA_W)) begin
              // Oversize transfer: answer with ERROR, never touch APB.
              r_state <= ST_ERR1;
              r_hresp <= HRESP_ERROR;
            end else begin
              r_state   <= ST_SETUP;
              r_hresp   <= HRESP_OKAY;
              r_paddr   <= haddr;
              r_pwrite  <= hwrite;
              r_psel    <= 1'b1;
              r_penable <= 1'b0;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
          end
        end

        ST_SETUP: begin
          // hwdata is valid in this AHB data-phase cycle; hold it for ACCESS.
          r_pwdata  <= hwdata;
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            if (pslverr) begin
              r_state <= ST_ERR1;
              r_hresp <= HRESP_ERROR;
            end else begin
              r_state     <= ST_DONE;
              r_hreadyout <= 1'b1;
              if (!r_pwrite) begin
                r_hrdata <= prdata;
              end
            end
          end else if (w_expired) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= ST_ERR1;
            r_hresp   <= HRESP_ERROR;
          end
        end

        // Second half of the AHB two-cycle error response.
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
        end
      endcase
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = r_hrdata;
  assign paddr     = r_paddr;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  // During SETUP the write data is passed straight through from the AHB bus.
  assign pwdata    = (r_state == ST_SETUP) ? hwdata : r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_cr_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cr_ahb2apb_bridge
//  Description : Directed self-checking bench for cr_ahb2apb_bridge
//                (TIMEOUT = 4). Inputs change 1 ns after the rising edge,
//                outputs are checked on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cr_ahb2apb_bridge;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Single-slave system: the bus ready is this slave's own ready.
  assign hready = hreadyout;

  cr_ahb2apb_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic addr_phase(input logic [1:0] tr, input logic wr,
                            input logic [31:0] a, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = tr;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic no_addr();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  initial begin
    rst     = 1'b1;
    hsel    = 1'b0;
    haddr   = '0;
    htrans  = 2'b00;
    hwrite  = 1'b0;
    hsize   = 3'd2;
    hwdata  = '0;
    prdata  = '0;
    pready  = 1'b1;
    pslverr = 1'b0;

    // ---------------- reset state ----------------
    tick(); mid();
    chk("rst_hreadyout", hreadyout, 1);
    chk("rst_hresp",     hresp,     0);
    chk("rst_hrdata",    hrdata,    0);
    chk("rst_psel",      psel,      0);
    chk("rst_penable",   penable,   0);
    chk("rst_pwrite",    pwrite,    0);
    chk("rst_paddr",     paddr,     0);
    chk("rst_pwdata",    pwdata,    0);
    tick(); rst = 1'b0;

    // ---------------- 1: write, zero-wait APB ----------------
    addr_phase(2'b10, 1'b1, 32'h40, 3'd2); pready = 1'b1;     // accept cycle N
    mid();
    chk("t1_idle_psel", psel, 0);
    tick(); no_addr(); hwdata = 32'hDEADBEEF;                   // N+1 SETUP
    mid();
    chk("t1_setup_psel",    psel,      1);
    chk("t1_setup_penable", penable,   0);
    chk("t1_setup_hready",  hreadyout, 0);
    chk("t1_setup_paddr",   paddr,     32'h40);
    chk("t1_setup_pwrite",  pwrite,    1);
    chk("t1_setup_pwdata",  pwdata,    32'hDEADBEEF);
    tick(); hwdata = 32'h0;                                     // N+2 ACCESS
    mid();
    chk("t1_acc_penable", penable,   1);
    chk("t1_acc_psel",    psel,      1);
    chk("t1_acc_pwdata",  pwdata,    32'hDEADBEEF);
    chk("t1_acc_paddr",   paddr,     32'h40);
    chk("t1_acc_hready",  hreadyout, 0);
    tick();                                                     // N+3 DONE
    mid();
    chk("t1_done_hready", hreadyout, 1);
    chk("t1_done_hresp",  hresp,     0);
    chk("t1_done_psel",   psel,      0);

    // ---------------- 2: read with 3 APB wait cycles ----------------
    tick();                                                     // IDLE
    addr_phase(2'b10, 1'b0, 32'h44, 3'd2); pready = 1'b0; prdata = 32'h12345678;
    tick(); no_addr();                                          // SETUP
    mid();
    chk("t2_setup_hready", hreadyout, 0);
    chk("t2_setup_pwrite", pwrite,    0);
    chk("t2_setup_paddr",  paddr,     32'h44);
    for (int i = 0; i < 3; i++) begin                           // ACCESS 1..3
      tick(); mid();
      chk("t2_acc_wait_hready",  hreadyout, 0);
      chk("t2_acc_wait_penable", penable,   1);
    end
    chk("t2_acc_hrdata_old", hrdata, 0);
    tick(); pready = 1'b1;                                      // ACCESS 4
    mid();
    chk("t2_acc4_hready", hreadyout, 0);
    tick();                                                     // DONE
    mid();
    chk("t2_done_hready", hreadyout, 1);
    chk("t2_done_hresp",  hresp,     0);
    chk("t2_done_hrdata", hrdata,    32'h12345678);

    // ---------------- 3: write with PSLVERR ----------------
    tick();                                                     // IDLE
    addr_phase(2'b10, 1'b1, 32'h48, 3'd2); pslverr = 1'b1; prdata = 32'hFFFF0000;
    tick(); no_addr(); hwdata = 32'hCAFEF00D;                   // SETUP
    tick();                                                     // ACCESS
    tick();                                                     // ERR1
    mid();
    chk("t3_err1_hready", hreadyout, 0);
    chk("t3_err1_hresp",  hresp,     1);
    chk("t3_err1_psel",   psel,      0);
    tick(); pslverr = 1'b0;                                     // ERR2
    mid();
    chk("t3_err2_hready", hreadyout, 1);
    chk("t3_err2_hresp",  hresp,     1);
    tick();                                                     // IDLE
    mid();
    chk("t3_idle_hresp",  hresp,     0);
    chk("t3_idle_hrdata", hrdata,    32'h12345678);

    // ---------------- 4: oversize HSIZE read ----------------
    addr_phase(2'b10, 1'b0, 32'h50, 3'd3);
    tick(); no_addr(); hsize = 3'd2;                            // ERR1
    mid();
    chk("t4_err1_psel",   psel,      0);
    chk("t4_err1_hready", hreadyout, 0);
    chk("t4_err1_hresp",  hresp,     1);
    tick();                                                     // ERR2
    mid();
    chk("t4_err2_psel",   psel,      0);
    chk("t4_err2_hready", hreadyout, 1);
    chk("t4_err2_hresp",  hresp,     1);
    chk("t4_err2_hrdata", hrdata,    32'h12345678);

    // ---------------- 5: APB timeout (TIMEOUT = 4) ----------------
    tick();                                                     // IDLE
    addr_phase(2'b10, 1'b0, 32'h60, 3'd2); pready = 1'b0; prdata = 32'hA5A5A5A5;
    tick(); no_addr();                                          // SETUP
    for (int i = 0; i < 4; i++) begin                           // ACCESS 1..4
      tick(); mid();
      chk("t5_acc_penable", penable, 1);
    end
    tick();                                                     // ERR1
    mid();
    chk("t5_err1_psel",    psel,      0);
    chk("t5_err1_penable", penable,   0);
    chk("t5_err1_hready",  hreadyout, 0);
    chk("t5_err1_hresp",   hresp,     1);
    chk("t5_err1_hrdata",  hrdata,    32'h12345678);
    tick(); pready = 1'b1;                                      // ERR2, accept next
    mid();
    chk("t5_err2_hresp", hresp, 1);
    addr_phase(2'b10, 1'b1, 32'h64, 3'd2);
    tick(); no_addr(); hwdata = 32'h0BADF00D;                   // SETUP
    mid();
    chk("t5b_setup_psel",   psel,   1);
    chk("t5b_setup_hresp",  hresp,  0);
    chk("t5b_setup_pwdata", pwdata, 32'h0BADF00D);
    tick();                                                     // ACCESS
    tick();                                                     // DONE
    mid();
    chk("t5b_done_hready", hreadyout, 1);
    chk("t5b_done_hresp",  hresp,     0);

    // ---------------- 6: back-to-back writes, then reset mid-ACCESS -----
    addr_phase(2'b10, 1'b1, 32'h70, 3'd2);                      // accept in DONE
    tick(); no_addr(); hwdata = 32'h11111111;                   // SETUP
    mid();
    chk("t6a_setup_paddr", paddr, 32'h70);
    tick();                                                     // ACCESS
    tick();                                                     // DONE
    mid();
    chk("t6_gap_psel", psel, 0);
    addr_phase(2'b11, 1'b1, 32'h74, 3'd2);
    tick(); no_addr(); hwdata = 32'h22222222; pready = 1'b0;    // SETUP
    mid();
    chk("t6b_setup_psel",  psel,  1);
    chk("t6b_setup_paddr", paddr, 32'h74);
    tick();                                                     // ACCESS
    mid();
    chk("t6b_acc_penable", penable, 1);
    chk("t6b_acc_pwdata",  pwdata,  32'h22222222);
    rst = 1'b1;
    #1;
    chk("t6_rst_psel",    psel,      0);
    chk("t6_rst_penable", penable,   0);
    chk("t6_rst_hready",  hreadyout, 1);
    chk("t6_rst_hresp",   hresp,     0);
    tick(); rst = 1'b0; pready = 1'b1;
    mid();
    chk("t6_post_psel",   psel,      0);
    chk("t6_post_hready", hreadyout, 1);
    tick(); tick(); mid();
    chk("t6_idle_psel", psel, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
